// File: rtl/fifo_sync_param.sv
// fifo_sync_param: single-clock FIFO with any depth >= 2, programmable
// almost-full/almost-empty thresholds, occupancy count and optional FWFT.
// Ports:
//   clk, rst                  rising-edge clock, sync active-high reset
//   data_in, wr_en            write data and write request
//   rd_en                     read request (pop/acknowledge when FWFT=1)
//   data_out, rd_valid        read data and its valid flag
//   wr_ack, overflow          previous cycle's write accepted / rejected
//   underflow                 previous cycle's read rejected
//   full, empty               count == FIFO_DEPTH / count == 0
//   almostfull, almostempty   count >= AF_THRESH / count <= AE_THRESH
//   count                     occupancy, $clog2(FIFO_DEPTH+1) bits
module fifo_sync_param #(
   parameter int FIFO_WIDTH = 16,
   parameter int FIFO_DEPTH = 8,
   parameter int AF_THRESH  = FIFO_DEPTH - 1,
   parameter int AE_THRESH  = 1,
   parameter bit FWFT       = 1'b0,
   localparam int CW        = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [FIFO_WIDTH-1:0] data_in,
   input  logic                  wr_en,
   input  logic                  rd_en,
   output logic [FIFO_WIDTH-1:0] data_out,
   output logic                  rd_valid,
   output logic                  wr_ack,
   output logic                  overflow,
   output logic                  underflow,
   output logic                  full,
   output logic                  empty,
   output logic                  almostfull,
   output logic                  almostempty,
   output logic [CW-1:0]         count
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [PW-1:0] LAST = PW'(FIFO_DEPTH - 1);

   if (FIFO_DEPTH < 2 || AE_THRESH < 1 || AE_THRESH >= AF_THRESH ||
       AF_THRESH > FIFO_DEPTH) begin : g_bad_param
      $error("fifo_sync_param: illegal depth/threshold parameters");
   end

   logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic [FIFO_WIDTH-1:0] data_q, data_d;
   logic                  valid_q, valid_d;
   logic                  wr_ack_q, ovf_q, unf_q;
   logic                  wr_go, rd_go;

   assign full        = (count_q == CW'(FIFO_DEPTH));
   assign empty       = (count_q == '0);
   assign almostfull  = (count_q >= CW'(AF_THRESH));
   assign almostempty = (count_q <= CW'(AE_THRESH));
   assign count       = count_q;

   assign wr_go = wr_en & ~full;
   assign rd_go = rd_en & ~empty;

   // Pointers wrap by compare so non-power-of-two depths work.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      data_d   = data_q;
      valid_d  = 1'b0;
      if (wr_go) begin
         wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
      end
      if (rd_go) begin
         rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
         data_d   = mem[rd_ptr_q];
         valid_d  = 1'b1;
      end
      unique case ({wr_go, rd_go})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         wr_ack_q <= 1'b0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         wr_ack_q <= wr_go;
         ovf_q    <= wr_en & full;
         unf_q    <= rd_en & empty;
      end
   end

   // Storage is not reset; a reset cycle simply blocks the write.
   always_ff @(posedge clk) begin
      if (!rst && wr_go) begin
         mem[wr_ptr_q] <= data_in;
      end
   end

   assign wr_ack    = wr_ack_q;
   assign overflow  = ovf_q;
   assign underflow = unf_q;

   if (FWFT) begin : g_fwft
      // Head word is shown directly; zero while empty so stale
      // storage never leaks onto the bus.
      assign data_out = empty ? '0 : mem[rd_ptr_q];
      assign rd_valid = ~empty;
   end else begin : g_reg
      assign data_out = data_q;
      assign rd_valid = valid_q;
   end

endmodule
